tx_sym_seq: RTL and testbench



---
 rtl/pcie_sym_pkg.sv | 65 ++++++
 rtl/tx_sym_seq_skp_timer.sv | 34 +++
 rtl/tx_sym_seq.sv | 193 +++++++++++++++++++
 tb/tb_tx_sym_seq.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_sym_pkg.sv
// Shared definitions for the transmit symbol sequencer: mux select codes,
// K-code byte values and the sequencer state encoding.
// Optional macro TXSEQ_FTS_EN adds the FTS ordered-set states.
package pcie_sym_pkg;

    // Select codes understood by the K-code mux controller
    localparam logic [3:0] SEL_DATA = 4'd0;
    localparam logic [3:0] SEL_COM  = 4'd1;
    localparam logic [3:0] SEL_PAD  = 4'd2;
    localparam logic [3:0] SEL_SKP  = 4'd3;
    localparam logic [3:0] SEL_STP  = 4'd4;
    localparam logic [3:0] SEL_SDP  = 4'd5;
    localparam logic [3:0] SEL_END  = 4'd6;
    localparam logic [3:0] SEL_EDB  = 4'd7;
    localparam logic [3:0] SEL_FTS  = 4'd8;
    localparam logic [3:0] SEL_IDL  = 4'd9;

    // K-code byte values the mux substitutes for each select code
    localparam logic [7:0] K_COM = 8'hBC;
    localparam logic [7:0] K_PAD = 8'hF7;
    localparam logic [7:0] K_SKP = 8'h1C;
    localparam logic [7:0] K_STP = 8'hFB;
    localparam logic [7:0] K_SDP = 8'h5C;
    localparam logic [7:0] K_END = 8'hFD;
    localparam logic [7:0] K_EDB = 8'hFE;
    localparam logic [7:0] K_FTS = 8'h3C;
    localparam logic [7:0] K_IDL = 8'h7C;

    // Sequencer states
    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_DATA = 4'd1,
        ST_TAIL = 4'd2,
        ST_SKP1 = 4'd3,
        ST_SKP2 = 4'd4,
        ST_SKP3 = 4'd5
`ifdef TXSEQ_FTS_EN
        ,
        ST_FTS1 = 4'd6,
        ST_FTS2 = 4'd7,
        ST_FTS3 = 4'd8
`endif
    } state_t;

    // Byte the mux puts on the wire for a given select code (data path
    // passes through, so DATA maps to 00 here)
    function automatic logic [7:0] kcode_byte(input logic [3:0] sel);
        logic [7:0] b;
        b = 8'h00;
        case (sel)
            SEL_COM: b = K_COM;
            SEL_PAD: b = K_PAD;
            SEL_SKP: b = K_SKP;
            SEL_STP: b = K_STP;
            SEL_SDP: b = K_SDP;
            SEL_END: b = K_END;
            SEL_EDB: b = K_EDB;
            SEL_FTS: b = K_FTS;
            SEL_IDL: b = K_IDL;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/tx_sym_seq_skp_timer.sv
// SKP interval timer: counts symbol cycles, saturates at SKP_INTERVAL-1 and
// then raises skp_due until the sequencer clears it by emitting a SKP COM.
module skp_timer
    import pcie_sym_pkg::*;
#(
    parameter int SKP_INTERVAL = 1180,
    parameter int CNT_W        = 11
)(
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    output logic o_skp_due
);

    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(SKP_INTERVAL - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_due;

    // Count up to saturation, then hold and flag; clear restarts the interval
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_cnt <= '0;
            r_due <= 1'b0;
        end else if (r_cnt == CNT_SAT) begin
            r_due <= 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_skp_due = r_due;

endmodule

// File: rtl/tx_sym_seq.sv
// Transmit symbol sequencer: frames packets from a byte-wide valid/ready
// source (STP/SDP, payload, END/EDB), inserts SKP ordered sets between
// packets and fills the link with IDL. One registered symbol per clock.
// Optional macro TXSEQ_FTS_EN adds fts_req and N_FTS FTS ordered sets.
//
// Source handshake: a byte transfers on a rising edge where pkt_valid and
// pkt_ready are both high. pkt_ready depends only on the current state, so
// the source may hold pkt_valid across non-ready cycles without side effects.
module tx_sym_seq
    import pcie_sym_pkg::*;
#(
    parameter int SKP_INTERVAL = 1180,
    parameter int CNT_W        = 11
`ifdef TXSEQ_FTS_EN
    ,
    parameter int N_FTS        = 4
`endif
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       pkt_valid,
    input  logic [7:0] pkt_data,
    input  logic       pkt_last,
    input  logic       pkt_dllp,
    input  logic       pkt_abort,
`ifdef TXSEQ_FTS_EN
    input  logic       fts_req,
`endif
    output logic       pkt_ready,
    output logic [7:0] mux_data,
    output logic       mux_enb,
    output logic [3:0] mux_sel,
    output logic [3:0] o_dbg_state
);

    state_t     r_state;
    logic [7:0] r_mux_data;
    logic [3:0] r_mux_sel;
    logic       r_mux_enb;
    logic       r_abort;

    state_t     w_nxt_state;
    logic [7:0] w_nxt_data;
    logic [3:0] w_nxt_sel;
    logic       w_nxt_abort;
    logic       w_skp_clear;
    logic       w_skp_due;

`ifdef TXSEQ_FTS_EN
    localparam logic [7:0] FTS_LAST = 8'(N_FTS - 1);

    logic       r_fts_pend;
    logic [7:0] r_fts_rep;
    logic       w_nxt_fts_pend;
    logic [7:0] w_nxt_fts_rep;
`endif

    skp_timer #(
        .SKP_INTERVAL (SKP_INTERVAL),
        .CNT_W        (CNT_W)
    ) u_skp_timer (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_clear   (w_skp_clear),
        .o_skp_due (w_skp_due)
    );

    // Next state and next symbol; IDLE is the only place a new ordered set
    // or packet may begin, so packets are never split by a SKP
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_sel   = SEL_IDL;
        w_nxt_data  = 8'h00;
        w_nxt_abort = r_abort;
        w_skp_clear = 1'b0;
`ifdef TXSEQ_FTS_EN
        w_nxt_fts_pend = r_fts_pend | fts_req;
        w_nxt_fts_rep  = r_fts_rep;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_skp_due) begin
                    w_nxt_sel   = SEL_COM;
                    w_skp_clear = 1'b1;
                    w_nxt_state = ST_SKP1;
`ifdef TXSEQ_FTS_EN
                end else if (r_fts_pend) begin
                    // FTS sets do not restart the SKP interval
                    w_nxt_sel   = SEL_COM;
                    w_nxt_state = ST_FTS1;
`endif
                end else if (pkt_valid) begin
                    w_nxt_sel   = pkt_dllp ? SEL_SDP : SEL_STP;
                    w_nxt_state = ST_DATA;
                end else begin
                    w_nxt_sel   = SEL_IDL;
                end
            end
            ST_DATA: begin
                if (pkt_valid) begin
                    w_nxt_sel  = SEL_DATA;
                    w_nxt_data = pkt_data;
                    if (pkt_last) begin
                        w_nxt_abort = pkt_abort;
                        w_nxt_state = ST_TAIL;
                    end
                end else begin
                    // source underrun: pad the link, keep the packet open
                    w_nxt_sel = SEL_PAD;
                end
            end
            ST_TAIL: begin
                w_nxt_sel   = r_abort ? SEL_EDB : SEL_END;
                w_nxt_abort = 1'b0;
                w_nxt_state = ST_IDLE;
            end
            ST_SKP1: begin
                w_nxt_sel   = SEL_SKP;
                w_nxt_state = ST_SKP2;
            end
            ST_SKP2: begin
                w_nxt_sel   = SEL_SKP;
                w_nxt_state = ST_SKP3;
            end
            ST_SKP3: begin
                w_nxt_sel   = SEL_SKP;
                w_nxt_state = ST_IDLE;
            end
`ifdef TXSEQ_FTS_EN
            ST_FTS1: begin
                w_nxt_sel   = SEL_FTS;
                w_nxt_state = ST_FTS2;
            end
            ST_FTS2: begin
                w_nxt_sel   = SEL_FTS;
                w_nxt_state = ST_FTS3;
            end
            ST_FTS3: begin
                // each set returns to IDLE; the pending flag starts the next
                w_nxt_sel   = SEL_FTS;
                w_nxt_state = ST_IDLE;
                if (r_fts_rep == FTS_LAST) begin
                    w_nxt_fts_rep  = 8'd0;
                    w_nxt_fts_pend = fts_req;
                end else begin
                    w_nxt_fts_rep  = r_fts_rep + 8'd1;
                end
            end
`endif
            default: begin
                w_nxt_sel   = SEL_IDL;
                w_nxt_state = ST_IDLE;
            end
        endcase
    end

    // State, abort latch and the registered mux outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_abort    <= 1'b0;
            r_mux_sel  <= SEL_IDL;
            r_mux_data <= 8'h00;
            r_mux_enb  <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_abort    <= w_nxt_abort;
            r_mux_sel  <= w_nxt_sel;
            r_mux_data <= w_nxt_data;
            r_mux_enb  <= 1'b1;
        end
    end

`ifdef TXSEQ_FTS_EN
    // FTS request latch and ordered-set repeat counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fts_pend <= 1'b0;
            r_fts_rep  <= 8'd0;
        end else begin
            r_fts_pend <= w_nxt_fts_pend;
            r_fts_rep  <= w_nxt_fts_rep;
        end
    end
`endif

    assign pkt_ready   = (r_state == ST_DATA);
    assign mux_data    = r_mux_data;
    assign mux_sel     = r_mux_sel;
    assign mux_enb     = r_mux_enb;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_tx_sym_seq.sv
// Bench for tx_sym_seq with a short SKP interval. A symbol-stream model
// (elapsed-time SKP scheduling plus a queue of committed symbols) predicts
// every output each cycle; directed cases pin the model with literal
// sequences taken straight from the framing rules.
module tb_tx_sym_seq;

    localparam int SKP_INTERVAL = 16;
    localparam int CNT_W        = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       pkt_valid;
    logic [7:0] pkt_data;
    logic       pkt_last;
    logic       pkt_dllp;
    logic       pkt_abort;
    logic       pkt_ready;
    logic [7:0] mux_data;
    logic       mux_enb;
    logic [3:0] mux_sel;
    logic [3:0] dbg_state;

    tx_sym_seq #(
        .SKP_INTERVAL (SKP_INTERVAL),
        .CNT_W        (CNT_W)
    ) dut (
`ifdef TXSEQ_FTS_EN
        .fts_req     (1'b0),
`endif
        .clk         (clk),
        .reset       (reset),
        .pkt_valid   (pkt_valid),
        .pkt_data    (pkt_data),
        .pkt_last    (pkt_last),
        .pkt_dllp    (pkt_dllp),
        .pkt_abort   (pkt_abort),
        .pkt_ready   (pkt_ready),
        .mux_data    (mux_data),
        .mux_enb     (mux_enb),
        .mux_sel     (mux_sel),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         cyc = 0;
    int         last_com = 0;
    bit         in_pkt = 0;
    bit         model_ok = 0;
    logic [3:0] exp_q[$];
    logic [3:0] exp_sel;
    logic [7:0] exp_data;
    logic       exp_enb;
    logic       exp_ready;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            exp_data = 8'h00;
            if (reset) begin
                exp_sel  = 4'd9;
                exp_enb  = 1'b0;
                exp_q.delete();
                in_pkt   = 0;
                last_com = cyc;
            end else begin
                exp_enb = 1'b1;
                if (exp_q.size() != 0) begin
                    exp_sel = exp_q.pop_front();
                end else if (in_pkt) begin
                    if (pkt_valid) begin
                        exp_sel  = 4'd0;
                        exp_data = pkt_data;
                        if (pkt_last) begin
                            in_pkt = 0;
                            exp_q.push_back(pkt_abort ? 4'd7 : 4'd6);
                        end
                    end else begin
                        exp_sel = 4'd2;
                    end
                end else if (cyc - last_com >= SKP_INTERVAL + 1) begin
                    exp_sel  = 4'd1;
                    last_com = cyc;
                    repeat (3) exp_q.push_back(4'd3);
                end else if (pkt_valid) begin
                    exp_sel = pkt_dllp ? 4'd5 : 4'd4;
                    in_pkt  = 1;
                end else begin
                    exp_sel = 4'd9;
                end
            end
            exp_ready = in_pkt && (exp_q.size() == 0);
            model_ok  = 1;
        end
    end

    // ---------------- scoreboard compare + symbol log ----------------
    logic [3:0] sel_log[$];
    logic [7:0] data_log[$];
    int         cyc_log[$];

    initial begin
        forever begin
            @(negedge clk);
            if (model_ok) begin
                check("mux_sel",   mux_sel,   exp_sel);
                check("mux_data",  mux_data,  exp_data);
                check("mux_enb",   mux_enb,   exp_enb);
                check("pkt_ready", pkt_ready, exp_ready);
                sel_log.push_back(mux_sel);
                data_log.push_back(mux_data);
                cyc_log.push_back(cyc);
            end
        end
    end

    function automatic int find_sel(input int after_cyc, input int s);
        for (int i = 0; i < sel_log.size(); i++)
            if (cyc_log[i] > after_cyc && sel_log[i] == 4'(s)) return i;
        return -1;
    endfunction

    int exp_sels[8];
    int exp_datas[8];

    task automatic expect_seq(input string name, input int after_cyc, input int n);
        int j;
        j = find_sel(after_cyc, exp_sels[0]);
        if (j < 0) begin
            check({name, "_start_found"}, 0, 1);
            return;
        end
        for (int k = 0; k < n; k++) begin
            if (j + k >= sel_log.size()) begin
                check({name, "_length"}, 0, 1);
                return;
            end
            check({name, "_sel"},  sel_log[j+k],  exp_sels[k]);
            check({name, "_data"}, data_log[j+k], exp_datas[k]);
        end
    endtask

    // ---------------- driver tasks ----------------
    logic [7:0] pkt_buf[$];

    task automatic do_reset(output int mark);
        reset     = 1'b1;
        pkt_valid = 1'b0;
        pkt_last  = 1'b0;
        pkt_abort = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_sel",   mux_sel,   4'd9);
        check("rst_enb",   mux_enb,   1'b0);
        check("rst_data",  mux_data,  8'h00);
        check("rst_ready", pkt_ready, 1'b0);
        mark  = cyc;
        reset = 1'b0;
    endtask

    task automatic send_pkt(input bit dllp, input bit abort, input int gap_at,
                            input int gap_len, input int rst_at, output int n_hs);
        int i = 0;
        int gap = 0;
        int guard = 0;
        bit hs;
        bit in_gap;
        n_hs = 0;
        while (i < pkt_buf.size()) begin
            in_gap    = (i == gap_at) && (gap < gap_len) && (pkt_ready == 1'b1);
            pkt_valid = !in_gap;
            pkt_data  = in_gap ? 8'($urandom) : pkt_buf[i];
            pkt_last  = (i == pkt_buf.size() - 1);
            pkt_dllp  = dllp;
            pkt_abort = pkt_last ? abort : 1'($urandom_range(0, 1));
            if (in_gap) gap++;
            hs = pkt_valid && pkt_ready;
            if (hs && i == rst_at) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                check("midrst_sel",   mux_sel,   4'd9);
                check("midrst_enb",   mux_enb,   1'b0);
                check("midrst_ready", pkt_ready, 1'b0);
                pkt_valid = 1'b0;
                return;
            end
            @(negedge clk);
            if (hs) begin
                i++;
                n_hs++;
            end
            guard++;
            if (guard > 400) begin
                check("send_timeout", 0, 1);
                break;
            end
        end
        pkt_valid = 1'b0;
        pkt_last  = 1'b0;
        pkt_abort = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int m;
        int m2;
        int n_hs;
        int j;
        int k;
        int bad;
        reset     = 1'b1;
        pkt_valid = 1'b0;
        pkt_data  = 8'h00;
        pkt_last  = 1'b0;
        pkt_dllp  = 1'b0;
        pkt_abort = 1'b0;
        @(negedge clk);

        // idle link: IDL fill, periodic COM,SKP,SKP,SKP every 17 cycles
        do_reset(m);
        repeat (45) @(negedge clk);
        j = find_sel(m, 1);
        if (j < 0) check("idle_com_found", 0, 1);
        else begin
            check("idle_first_com_cycle", cyc_log[j] - m, 17);
            bad = 0;
            for (int i = 0; i < j; i++)
                if (cyc_log[i] > m && sel_log[i] != 4'd9) bad++;
            check("idle_fill_is_idl", bad, 0);
            check("idle_skp1", sel_log[j+1], 3);
            check("idle_skp2", sel_log[j+2], 3);
            check("idle_skp3", sel_log[j+3], 3);
            check("idle_after_os", sel_log[j+4], 9);
            k = find_sel(cyc_log[j], 1);
            if (k < 0) check("idle_second_com_found", 0, 1);
            else check("idle_os_spacing", cyc_log[k] - cyc_log[j], 17);
        end

        // 3-byte TLP
        do_reset(m);
        pkt_buf = '{8'hA1, 8'hB2, 8'hC3};
        send_pkt(0, 0, -1, 0, -1, n_hs);
        check("tlp_handshakes", n_hs, 3);
        repeat (3) @(negedge clk);
        exp_sels  = '{4, 0, 0, 0, 6, 0, 0, 0};
        exp_datas = '{0, 'hA1, 'hB2, 'hC3, 0, 0, 0, 0};
        expect_seq("tlp3", m, 5);

        // aborted DLLP then back-to-back TLP
        do_reset(m);
        pkt_buf = '{8'h11, 8'h22};
        send_pkt(1, 1, -1, 0, -1, n_hs);
        pkt_buf = '{8'h33};
        send_pkt(0, 0, -1, 0, -1, n_hs);
        repeat (3) @(negedge clk);
        exp_sels  = '{5, 0, 0, 7, 4, 0, 6, 0};
        exp_datas = '{0, 'h11, 'h22, 0, 0, 'h33, 0, 0};
        expect_seq("dllp_abort_b2b", m, 7);

        // underrun: two PAD symbols between payload bytes
        do_reset(m);
        pkt_buf = '{8'h44, 8'h55, 8'h66};
        send_pkt(0, 0, 1, 2, -1, n_hs);
        repeat (3) @(negedge clk);
        exp_sels  = '{4, 0, 2, 2, 0, 0, 6, 0};
        exp_datas = '{0, 'h44, 0, 0, 'h55, 'h66, 0, 0};
        expect_seq("underrun_pad", m, 7);

        // SKP comes due mid-packet while another packet waits
        do_reset(m);
        pkt_buf.delete();
        for (int i = 0; i < 20; i++) pkt_buf.push_back(8'(i + 1));
        send_pkt(0, 0, -1, 0, -1, n_hs);
        pkt_buf = '{8'h77};
        send_pkt(0, 0, -1, 0, -1, n_hs);
        repeat (3) @(negedge clk);
        j = find_sel(m, 1);
        k = find_sel(m, 6);
        check("skp_not_inside_pkt", (j > k) ? 1 : 0, 1);
        exp_sels  = '{6, 1, 3, 3, 3, 4, 0, 6};
        exp_datas = '{0, 0, 0, 0, 0, 0, 'h77, 0};
        expect_seq("skp_after_pkt", m, 8);

        // reset during the second byte, then the packet is re-sent
        do_reset(m);
        pkt_buf = '{8'hD0, 8'hD1, 8'hD2, 8'hD3};
        send_pkt(0, 0, -1, 0, 1, n_hs);
        m2 = cyc;
        send_pkt(0, 0, -1, 0, -1, n_hs);
        repeat (3) @(negedge clk);
        exp_sels  = '{4, 0, 0, 0, 0, 6, 0, 0};
        exp_datas = '{0, 'hD0, 'hD1, 'hD2, 'hD3, 0, 0, 0};
        expect_seq("resend_after_rst", m2, 6);

        // randomized traffic against the model
        for (int p = 0; p < 120; p++) begin
            int len;
            len = $urandom_range(1, 8);
            pkt_buf.delete();
            for (int b = 0; b < len; b++) pkt_buf.push_back(8'($urandom));
            send_pkt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $urandom_range(0, len - 1), $urandom_range(0, 2), -1, n_hs);
            check("rand_handshakes", n_hs, len);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        repeat (40) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
